// File: rtl/rggen_rtl_pkg.sv
// rtl/rggen_rtl_pkg.sv - shared types and helpers for the interrupt coalescer
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        FLUSH
    } rggen_irq_coalescer_state_e;

    localparam int MAX_COUNT_WIDTH = 16;

    // Callers zero-extend narrower counters into this width and truncate the result back.
    function automatic logic [MAX_COUNT_WIDTH-1:0] sat_inc(
        input logic [MAX_COUNT_WIDTH-1:0] value,
        input logic                       inc,
        input logic [MAX_COUNT_WIDTH-1:0] max_value
    );
        if (inc && (value != max_value)) begin
            return value + 16'd1;
        end
        return value;
    endfunction

endpackage

// File: rtl/rggen_irq_coalescer_if.sv
// rtl/rggen_irq_coalescer_if.sv - event, status and set-pulse signals of the coalescer
interface rggen_irq_coalescer_if #(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 4,
    parameter int TIMER_WIDTH = 8
);
    logic [WIDTH-1:0]       i_event;
    logic [COUNT_WIDTH-1:0] i_threshold;
    logic [TIMER_WIDTH-1:0] i_timeout;
    logic [WIDTH-1:0]       i_enable;
    logic [WIDTH-1:0]       i_status;
    logic [WIDTH-1:0]       o_set;
    logic [WIDTH-1:0]       o_mask;
    logic                   o_irq;
    logic                   o_busy;

    modport master (
        output i_event, i_threshold, i_timeout, i_enable, i_status,
        input  o_set, o_mask, o_irq, o_busy
    );

    modport slave (
        input  i_event, i_threshold, i_timeout, i_enable, i_status,
        output o_set, o_mask, o_irq, o_busy
    );
endinterface

// File: rtl/rggen_irq_event_counter.sv
// rtl/rggen_irq_event_counter.sv - per-bit saturating event counter with threshold and flush
module rggen_irq_event_counter
    import rggen_rtl_pkg::*;
#(
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_event,
    input  logic [COUNT_WIDTH-1:0] i_threshold,
    input  logic                   i_flush,
    output logic                   o_set_hit,
    output logic                   o_nonzero,
    output logic                   o_nonzero_next
);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

    logic [COUNT_WIDTH-1:0] cnt;
    logic [COUNT_WIDTH-1:0] cnt_next;
    logic [COUNT_WIDTH-1:0] thr_eff;
    logic [COUNT_WIDTH:0]   sum;
    logic                   hit;
    logic                   flush_hit;

    assign thr_eff   = (i_threshold == '0) ? COUNT_WIDTH'(1) : i_threshold;
    assign sum       = {1'b0, cnt} + {{COUNT_WIDTH{1'b0}}, i_event};
    assign hit       = (sum >= {1'b0, thr_eff});
    assign flush_hit = i_flush && (cnt != '0);

    // A flushed bit restarts from this cycle's event so it is never lost.
    always_comb begin
        cnt_next = COUNT_WIDTH'(sat_inc(MAX_COUNT_WIDTH'(cnt), i_event, MAX_COUNT_WIDTH'(CNT_MAX)));
        if (hit) begin
            cnt_next = '0;
        end else if (flush_hit) begin
            cnt_next = COUNT_WIDTH'(i_event);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    assign o_set_hit      = hit || flush_hit;
    assign o_nonzero      = (cnt != '0);
    assign o_nonzero_next = (cnt_next != '0);
endmodule

// File: rtl/rggen_irq_coalescer.sv
// rtl/rggen_irq_coalescer.sv - interrupt moderation: threshold/holdoff set pulses and registered irq
module rggen_irq_coalescer
    import rggen_rtl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 4,
    parameter int TIMER_WIDTH = 8
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    rggen_irq_coalescer_if.slave bus
);
    rggen_irq_coalescer_state_e state;
    rggen_irq_coalescer_state_e state_next;
    logic [TIMER_WIDTH-1:0]     timer;
    logic [TIMER_WIDTH-1:0]     timer_next;
    logic                       flush;
    logic [WIDTH-1:0]           set_hit;
    logic [WIDTH-1:0]           nonzero;
    logic [WIDTH-1:0]           nonzero_next;
    logic                       any_next;
    logic                       timer_on;
    logic [WIDTH-1:0]           set_q;
    logic                       irq_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        rggen_irq_event_counter #(
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_counter (
            .i_clk          (i_clk),
            .i_rst_n        (i_rst_n),
            .i_event        (bus.i_event[i]),
            .i_threshold    (bus.i_threshold),
            .i_flush        (flush),
            .o_set_hit      (set_hit[i]),
            .o_nonzero      (nonzero[i]),
            .o_nonzero_next (nonzero_next[i])
        );
    end

    assign any_next = |nonzero_next;
    assign timer_on = (bus.i_timeout != '0);

    // The timeout is sampled only on (re)load, so changing it mid-count takes effect next round.
    always_comb begin
        state_next = state;
        timer_next = timer;
        flush      = 1'b0;
        case (state)
            IDLE: begin
                if (any_next && timer_on) begin
                    state_next = COUNT;
                    timer_next = bus.i_timeout;
                end
            end
            COUNT: begin
                timer_next = timer - TIMER_WIDTH'(1);
                if (!any_next) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (timer == TIMER_WIDTH'(1)) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (any_next && timer_on) begin
                    state_next = COUNT;
                    timer_next = bus.i_timeout;
                end else begin
                    state_next = IDLE;
                    timer_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            timer <= '0;
            set_q <= '0;
            irq_q <= 1'b0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            set_q <= set_hit;
            irq_q <= |(bus.i_status & bus.i_enable);
        end
    end

    assign bus.o_set  = set_q;
    assign bus.o_mask = bus.i_enable;
    assign bus.o_irq  = irq_q;
    assign bus.o_busy = |nonzero;
endmodule
